// File: rtl/v810_bus_pkg.sv
// Shared constants for the V810 bus resizer: device width codes and wait-counter sizing.
package v810_bus_pkg;

  localparam int DW_16 = 16;
  localparam int DW_32 = 32;
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // A 16-bit device only ever drives one halfword. The low lane is used when either low byte is enabled.
  function automatic logic [15:0] half_sel(input logic [3:0] ben, input logic [31:0] wide);
    return (ben[1:0] != 2'b11) ? wide[15:0] : wide[31:16];
  endfunction

endpackage

// File: rtl/v810_bus_resizer.sv
// Emulates a 16- or 32-bit device with programmable wait states in front of a 32-bit memory.
// All data steering is combinational. The only state is the wait counter.
module v810_bus_resizer
  import v810_bus_pkg::*;
(
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] WS,
  input  logic [31:0] DW,
  input  logic        CTLR_DAn,
  input  logic [3:0]  CTLR_BEn,
  output logic        CTLR_READYn,
  output logic        CTLR_SZRQn,
  output logic [31:0] CTLR_DI,
  input  logic [31:0] CTLR_DO,
  input  logic        MEM_nCE,
  output logic [31:0] MEM_DI,
  input  logic [31:0] MEM_DO
);

  logic  sel;
  logic  is16;
  logic  ws_hit;
  cnt_t  cnt_q, cnt_d;

  assign sel    = ~MEM_nCE & ~CTLR_DAn;
  assign is16   = (DW == DW_16);
  assign ws_hit = (32'(cnt_q) == WS);

  // The counter saturates at WS, so READYn stays low for the rest of the strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (!sel)
      cnt_d = '0;
    else if (!ws_hit)
      cnt_d = cnt_q + cnt_t'(1);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES)
      cnt_q <= '0;
    else if (CE)
      cnt_q <= cnt_d;
  end

  assign CTLR_READYn = ~(sel & ws_hit);
  assign CTLR_SZRQn  = ~(~MEM_nCE & is16);

  always_comb begin
    CTLR_DI = MEM_DO;
    MEM_DI  = CTLR_DO;
    if (is16) begin
      CTLR_DI = {2{half_sel(CTLR_BEn, MEM_DO)}};
      MEM_DI  = {2{CTLR_DO[15:0]}};
    end
  end

endmodule

// File: tb/tb_v810_bus_resizer.sv
// Directed checks of the bus resizer: wait-state timing, lane steering, abort, reset and clock-enable behaviour.
module tb_v810_bus_resizer;

  logic        CLK = 1'b0;
  logic        RES, CE, CTLR_DAn, MEM_nCE;
  logic [31:0] WS, DW, CTLR_DO, MEM_DO;
  logic [3:0]  CTLR_BEn;
  logic        CTLR_READYn, CTLR_SZRQn;
  logic [31:0] CTLR_DI, MEM_DI;

  int n_chk = 0;
  int n_pass = 0;

  v810_bus_resizer dut (
    .CLK(CLK), .RES(RES), .CE(CE), .WS(WS), .DW(DW),
    .CTLR_DAn(CTLR_DAn), .CTLR_BEn(CTLR_BEn), .CTLR_READYn(CTLR_READYn),
    .CTLR_SZRQn(CTLR_SZRQn), .CTLR_DI(CTLR_DI), .CTLR_DO(CTLR_DO),
    .MEM_nCE(MEM_nCE), .MEM_DI(MEM_DI), .MEM_DO(MEM_DO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 2ns past it.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Hold an access open and expect READYn high for n cycles, then low.
  task automatic expect_ready_after(input string tag, input int n);
    for (int i = 0; i <= n; i++) begin
      #1 chk(tag, {31'd0, CTLR_READYn}, (i == n) ? 32'd0 : 32'd1);
      if (i != n) tick();
    end
  endtask

  initial begin
    RES = 1'b1; CE = 1'b1; WS = 32'd0; DW = 32'd16;
    CTLR_DAn = 1'b1; MEM_nCE = 1'b1; CTLR_BEn = 4'hF;
    CTLR_DO = 32'h0; MEM_DO = 32'h0;
    tick();
    #1 chk("rst_idle_ready", {31'd0, CTLR_READYn}, 32'd1);
    chk("rst_idle_szrq", {31'd0, CTLR_SZRQn}, 32'd1);
    // A selected strobe with WS=0 reads as ready even while reset is held.
    MEM_nCE = 1'b0; CTLR_DAn = 1'b0;
    #1 chk("rst_ws0_ready", {31'd0, CTLR_READYn}, 32'd0);
    WS = 32'd2;
    tick(); tick();
    #1 chk("rst_ws2_ready", {31'd0, CTLR_READYn}, 32'd1);
    CTLR_DAn = 1'b1; MEM_nCE = 1'b1;
    tick();
    RES = 1'b0;
    tick();

    // 16-bit device, zero wait states, low lane.
    WS = 32'd0; DW = 32'd16; MEM_nCE = 1'b0; CTLR_DAn = 1'b0;
    CTLR_BEn = 4'b1100; MEM_DO = 32'hAAAA5555; CTLR_DO = 32'h1234ABCD;
    #1 chk("ws0_ready", {31'd0, CTLR_READYn}, 32'd0);
    chk("ws0_szrq", {31'd0, CTLR_SZRQn}, 32'd0);
    chk("ws0_di_lo", CTLR_DI, 32'h55555555);
    chk("ws0_mem_di", MEM_DI, 32'hABCDABCD);
    CTLR_BEn = 4'b1110;
    #1 chk("be1110_di_lo", CTLR_DI, 32'h55555555);
    tick();
    CTLR_DAn = 1'b1;
    tick();

    // 16-bit device, WS=2, upper lane.
    WS = 32'd2; CTLR_BEn = 4'b0011; MEM_DO = 32'h12345678; CTLR_DAn = 1'b0;
    #1 chk("ws2_di_hi", CTLR_DI, 32'h12341234);
    expect_ready_after("ws2_ready", 2);
    tick();
    CTLR_DAn = 1'b1;
    tick();

    // 32-bit device, WS=1: straight-through data.
    DW = 32'd32; WS = 32'd1; CTLR_BEn = 4'b0000;
    MEM_DO = 32'hDEADBEEF; CTLR_DO = 32'hCAFEF00D; CTLR_DAn = 1'b0;
    #1 chk("dw32_szrq", {31'd0, CTLR_SZRQn}, 32'd1);
    chk("dw32_di", CTLR_DI, 32'hDEADBEEF);
    chk("dw32_mem_di", MEM_DI, 32'hCAFEF00D);
    expect_ready_after("dw32_ready", 1);
    tick();
    CTLR_DAn = 1'b1;
    tick();

    // Device not selected: no ready and no size request for 10 cycles.
    DW = 32'd16; WS = 32'd3; MEM_nCE = 1'b1; CTLR_DAn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("nosel_ready", {31'd0, CTLR_READYn}, 32'd1);
      chk("nosel_szrq", {31'd0, CTLR_SZRQn}, 32'd1);
      tick();
    end
    // The counter must have stayed at 0, so a fresh select takes the full 3 waits.
    MEM_nCE = 1'b0;
    expect_ready_after("nosel_then_sel", 3);
    tick();
    CTLR_DAn = 1'b1;
    tick();

    // Aborted access after one cycle, then a new access.
    CTLR_DAn = 1'b0;
    #1 chk("abort_ready", {31'd0, CTLR_READYn}, 32'd1);
    tick();
    CTLR_DAn = 1'b1;
    #1 chk("abort_gap_ready", {31'd0, CTLR_READYn}, 32'd1);
    tick();
    CTLR_DAn = 1'b0;
    expect_ready_after("after_abort", 3);
    tick();
    CTLR_DAn = 1'b1;
    tick();

    // Asynchronous reset pulse at cnt=2 during a WS=4 access.
    WS = 32'd4; CTLR_DAn = 1'b0;
    tick(); tick();
    RES = 1'b1;
    #1 chk("midrst_ready", {31'd0, CTLR_READYn}, 32'd1);
    RES = 1'b0;
    expect_ready_after("postrst", 4);
    tick();
    CTLR_DAn = 1'b1;
    tick();

    // A CE=0 gap of two cycles stretches a WS=2 wait by two cycles.
    WS = 32'd2; CTLR_DAn = 1'b0;
    #1 chk("ce_c0", {31'd0, CTLR_READYn}, 32'd1);
    tick();
    CE = 1'b0;
    #1 chk("ce_c1", {31'd0, CTLR_READYn}, 32'd1);
    tick();
    #1 chk("ce_gap1", {31'd0, CTLR_READYn}, 32'd1);
    tick();
    #1 chk("ce_gap2", {31'd0, CTLR_READYn}, 32'd1);
    CE = 1'b1;
    tick();
    #1 chk("ce_done", {31'd0, CTLR_READYn}, 32'd0);
    CTLR_DAn = 1'b1;
    #1 chk("ce_release", {31'd0, CTLR_READYn}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/v810_bus_resizer.md
V810_BUS_RESIZER -- requirements
Module: v810_bus_resizer

Interface
REQ-001 Parameters: none; configuration comes from run-time inputs WS and DW.
REQ-002 CLK  in  1  system clock; all state changes on rising edge when CE=1.
REQ-003 RES  in  1  reset, asynchronous, active-high.
REQ-004 CE  in  1  clock enable; when 0, state holds.
REQ-005 WS  in  32 (int)  wait states per access, 0..15; must be stable during an access.
REQ-006 DW  in  32 (int)  emulated device data width; 16 means 16-bit device, any other value means 32-bit.
REQ-007 CTLR_DAn  in  1  bus-controller data strobe, active-low, held low for the whole access.
REQ-008 CTLR_BEn  in  4  byte enables, active-low.
REQ-009 CTLR_READYn  out  1  access-complete, active-low.
REQ-010 CTLR_SZRQn  out  1  bus-size request (16-bit), active-low.
REQ-011 CTLR_DI  out  32  read data to controller.
REQ-012 CTLR_DO  in  32  write data from controller.
REQ-013 MEM_nCE  in  1  device select, active-low, decoded externally.
REQ-014 MEM_DI  out  32  write data to the 32-bit backing memory.
REQ-015 MEM_DO  in  32  read data from the 32-bit backing memory.

Function
REQ-016 Define sel = ~MEM_nCE & ~CTLR_DAn.
REQ-017 Keep a 4-bit wait counter cnt.
  - cnt clears to 0 whenever sel=0.
  - When sel=1, cnt != WS and CE=1, cnt increments by 1 each cycle.
  - cnt saturates at WS.
REQ-018 CTLR_READYn = ~(sel & cnt==WS), combinational.
  - WS=0 gives READYn low in the first strobe cycle.
  - WS=n gives READYn low in cycle n+1 of the strobe.
REQ-019 CTLR_READYn is 1 whenever MEM_nCE=1, so it can be AND-combined with other devices.
REQ-020 CTLR_SZRQn = ~(~MEM_nCE & DW==16), combinational; it is 1 whenever the device is not selected or DW is 32.
REQ-021 Read path with DW=16, one halfword per access:
  - BEn[1:0] has any zero: hw = MEM_DO[15:0].
  - Otherwise: hw = MEM_DO[31:16].
  - CTLR_DI = {hw, hw}.
REQ-022 Read path with DW=32: CTLR_DI = MEM_DO.
REQ-023 Write path with DW=16: MEM_DI = {CTLR_DO[15:0], CTLR_DO[15:0]}; the external BEn selects the lane.
REQ-024 Write path with DW=32: MEM_DI = CTLR_DO.
REQ-025 Data paths are purely combinational; the block adds zero latency beyond the wait states.
REQ-026 Back-to-back accesses: CTLR_DAn must rise for at least one cycle between accesses; the counter restarts from 0.
REQ-027 If CTLR_DAn rises before READYn asserts (aborted access), cnt clears and no ready pulse is generated.
REQ-028 If CE=0 during an access, cnt holds and READYn keeps its combinational value.

Reset
REQ-029 While RES=1, cnt=0, so CTLR_READYn = ~(sel & WS==0).
REQ-030 After RES falls, the first access begins counting from 0.
REQ-031 Reset asserted mid-access clears cnt immediately (asynchronous).
REQ-032 Outputs are combinational, so none are registered.

Structure
REQ-033 Width codes (DW_16=16, DW_32=32) and the counter width (4) live in a shared package, v810_bus_pkg.
REQ-034 Single module with no sub-modules; the counter and lane mux are inline.

Verification
REQ-035 WS=0, DW=16, select, DAn low, BEn=1100, MEM_DO=0xAAAA5555 -> same cycle READYn=0, SZRQn=0, CTLR_DI=0x55555555.
REQ-036 WS=2, DW=16, BEn=0011, MEM_DO=0x12345678 -> READYn high for 2 CE cycles, low on the 3rd; CTLR_DI=0x12341234.
REQ-037 DW=32, WS=1, MEM_DO=0xDEADBEEF, CTLR_DO=0xCAFEF00D -> SZRQn=1, CTLR_DI=0xDEADBEEF, MEM_DI=0xCAFEF00D, ready on 2nd cycle.
REQ-038 MEM_nCE=1 with DAn low -> READYn=1, SZRQn=1 for 10 cycles; cnt stays 0.
REQ-039 WS=3, DAn raised after 1 cycle, then a new access -> no ready during the aborted access; new access ready after 3 waits.
REQ-040 RES pulsed during a WS=4 access at cnt=2 -> cnt=0 at once; after release, ready comes 4 cycles later; CE=0 gaps stretch the wait by the gap length.
